// File: rtl/mult_stall_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mult_stall_pipe
//
// Pipelined multiplier with per-stage valid/ready flow control. Stage 0
// captures the full-width product of the accepted operands; the remaining
// stages only move the result and its tag forward. Each stage advances
// whenever it is empty or its successor can take its contents. Empty stages
// (bubbles) are therefore squeezed out while the output is stalled, so the
// pipeline fills completely before it pushes back on the producer.
//
// Ports
//   clk        clock, rising edge
//   rstn       synchronous reset, active low
//   in_valid   operation offered
//   in_ready   operation accepted this cycle (held low during reset)
//   in_a/in_b  operands, DATA_W bits each
//   in_signed  1 = two's-complement operands, 0 = unsigned
//   in_tag     opaque tag that travels with the operation
//   out_valid  out_data/out_tag hold a result
//   out_ready  consumer takes the result this cycle
//   out_data   2*DATA_W-bit product
//   out_tag    tag of the presented result
//   count      number of valid stages
//   busy       count is non-zero
// ---------------------------------------------------------------------------

// Project-wide default sizes; fall back to these values when the
// surrounding build does not define them.
`ifndef FSIZE
`define FSIZE 16
`endif
`ifndef MULT_CYCLES
`define MULT_CYCLES 3
`endif

module mult_stall_pipe #(
    parameter int DATA_W = `FSIZE,
    parameter int STAGES = `MULT_CYCLES,
    parameter int TAG_W  = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_a,
    input  logic [DATA_W-1:0]              in_b,
    input  logic                           in_signed,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*DATA_W-1:0]            out_data,
    output logic [TAG_W-1:0]               out_tag,
    output logic [$clog2(STAGES+1)-1:0]    count,
    output logic                           busy
);

    localparam int                PROD_W  = 2 * DATA_W;
    localparam int                CNT_W   = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    // Pipeline state
    logic [STAGES-1:0]  valid_reg;
    logic [PROD_W-1:0]  data_reg [STAGES];
    logic [TAG_W-1:0]   tag_reg  [STAGES];
    logic [CNT_W-1:0]   count_reg;

    // Flow control
    logic [STAGES-1:0]  ready;
    logic               in_fire;
    logic               out_fire;

    // Multiplier
    logic [PROD_W-1:0]  ext_a;
    logic [PROD_W-1:0]  ext_b;
    logic [PROD_W-1:0]  product;

    // Extending both operands to the full product width (sign or zero, as
    // selected) makes the low PROD_W bits of a single unsigned multiply the
    // exact result for either interpretation.
    always_comb begin
        ext_a   = in_signed ? {{DATA_W{in_a[DATA_W-1]}}, in_a} : {{DATA_W{1'b0}}, in_a};
        ext_b   = in_signed ? {{DATA_W{in_b[DATA_W-1]}}, in_b} : {{DATA_W{1'b0}}, in_b};
        product = ext_a * ext_b;
    end

    // Ready ripples backwards from the output: a stage can load if it is
    // empty or if whatever it holds is moving on this cycle.
    always_comb begin
        ready             = '0;
        ready[STAGES-1]   = !valid_reg[STAGES-1] | out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            ready[i] = !valid_reg[i] | ready[i+1];
        end
    end

    assign in_ready = ready[0] & rstn;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = valid_reg[STAGES-1] & out_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_reg <= '0;
            count_reg <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_reg[i] <= '0;
                tag_reg[i]  <= '0;
            end
        end else begin
            // Stage 0 takes the offered operation or a bubble. The payload is
            // only written for a real operation so an idle input does not
            // toggle the product register.
            if (ready[0]) begin
                valid_reg[0] <= in_valid;
                if (in_valid) begin
                    data_reg[0] <= product;
                    tag_reg[0]  <= in_tag;
                end
            end

            for (int i = 1; i < STAGES; i++) begin
                if (ready[i]) begin
                    valid_reg[i] <= valid_reg[i-1];
                    data_reg[i]  <= data_reg[i-1];
                    tag_reg[i]   <= tag_reg[i-1];
                end
            end

            case ({in_fire, out_fire})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_data  = data_reg[STAGES-1];
    assign out_tag   = tag_reg[STAGES-1];
    assign count     = count_reg;
    assign busy      = (count_reg != '0);

endmodule
